// File: rtl/lane_distributor.sv
// lane_distributor: splits a 4-lane word into 1, 2 or 4 beats across byte lanes.
// A word is taken on in_valid && in_ready. Its beats are presented on registered
// lane outputs, starting in the cycle after acceptance.
module lane_distributor #(
    parameter int unsigned       LANE_W    = 8,
    parameter logic [LANE_W-1:0] IDLE_FILL = LANE_W'(8'h00)
) (
    input  logic                  clk_100mhz,
    input  logic                  rst_n,
    input  logic [4*LANE_W-1:0]   combined_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            lane_mode,
    output logic [LANE_W-1:0]     data_lane0,
    output logic [LANE_W-1:0]     data_lane1,
    output logic [LANE_W-1:0]     data_lane2,
    output logic [LANE_W-1:0]     data_lane3,
    output logic [3:0]            lane_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [15:0]           words_sent
);

    localparam int unsigned WORD_W = 4 * LANE_W;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // Index of the last beat for a given lane_mode: 1, 2 or 4 beats per word.
    function automatic logic [1:0] last_index(input logic [1:0] mode);
        logic [1:0] idx;
        case (mode)
            2'd0:    idx = 2'd0;
            2'd1:    idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Lane contents for beat b of word w; last selects the beat count.
    function automatic logic [WORD_W-1:0] map_lanes(input logic [WORD_W-1:0] w,
                                                    input logic [1:0]        last,
                                                    input logic [1:0]        b);
        logic [WORD_W-1:0] l;
        l = {4{IDLE_FILL}};
        case (last)
            2'd0: l = w;
            2'd1: l[0 +: 2*LANE_W] = b[0] ? w[2*LANE_W +: 2*LANE_W] : w[0 +: 2*LANE_W];
            default: begin
                case (b)
                    2'd0:    l[0 +: LANE_W] = w[0        +: LANE_W];
                    2'd1:    l[0 +: LANE_W] = w[LANE_W   +: LANE_W];
                    2'd2:    l[0 +: LANE_W] = w[2*LANE_W +: LANE_W];
                    default: l[0 +: LANE_W] = w[3*LANE_W +: LANE_W];
                endcase
            end
        endcase
        return l;
    endfunction

    // Per-lane valid pattern for a given beat count.
    function automatic logic [3:0] map_valid(input logic [1:0] last);
        logic [3:0] v;
        case (last)
            2'd0:    v = 4'b1111;
            2'd1:    v = 4'b0011;
            default: v = 4'b0001;
        endcase
        return v;
    endfunction

    logic [0:0]        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        beat_q, beat_d;
    logic [WORD_W-1:0] lanes_q, lanes_d;
    logic [3:0]        valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [15:0]       words_q, words_d;

    logic              last_beat_c;
    logic              accept_c;
    logic [1:0]        new_last_c;

    assign last_beat_c = (beat_q == last_q);
    assign in_ready    = (state_q == IDLE) || ((state_q == SEND) && last_beat_c && out_ready);
    assign accept_c    = in_valid && in_ready;
    assign new_last_c  = last_index(lane_mode);

    // State and datapath registers; reset discards any partially sent word.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            last_q  <= '0;
            beat_q  <= '0;
            lanes_q <= {4{IDLE_FILL}};
            valid_q <= '0;
            busy_q  <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            lanes_q <= lanes_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            words_q <= words_d;
        end
    end

    // Next-state and next-output logic: beat advance, word completion, accept.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        beat_d  = beat_q;
        lanes_d = lanes_q;
        valid_d = valid_q;
        words_d = words_q;

        case (state_q)
            IDLE: begin
                // out_ready has no meaning here; only an accept moves the FSM.
            end
            SEND: begin
                if (out_ready) begin
                    if (!last_beat_c) begin
                        beat_d  = beat_q + 2'd1;
                        lanes_d = map_lanes(word_q, last_q, beat_q + 2'd1);
                        valid_d = map_valid(last_q);
                    end else begin
                        words_d = words_q + 16'd1;
                        state_d = IDLE;
                        beat_d  = 2'd0;
                        lanes_d = {4{IDLE_FILL}};
                        valid_d = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                lanes_d = {4{IDLE_FILL}};
                valid_d = 4'b0000;
            end
        endcase

        // A new word overrides the return to IDLE, giving gap-free back-to-back words.
        if (accept_c) begin
            state_d = SEND;
            word_d  = combined_data;
            last_d  = new_last_c;
            beat_d  = 2'd0;
            lanes_d = map_lanes(combined_data, new_last_c, 2'd0);
            valid_d = map_valid(new_last_c);
        end

        busy_d = (state_d == SEND);
    end

    assign data_lane0 = lanes_q[0        +: LANE_W];
    assign data_lane1 = lanes_q[LANE_W   +: LANE_W];
    assign data_lane2 = lanes_q[2*LANE_W +: LANE_W];
    assign data_lane3 = lanes_q[3*LANE_W +: LANE_W];
    assign lane_valid = valid_q;
    assign busy       = busy_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_lane_distributor.sv
// Bench for lane_distributor: directed scenarios plus random traffic, all checked
// against a beat-queue reference model built from byte/lane arithmetic.
module tb_lane_distributor;

    localparam int unsigned LANE_W = 8;

    logic        clk_100mhz = 1'b0;
    logic        rst_n;
    logic [31:0] combined_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  lane_mode;
    logic [7:0]  data_lane0, data_lane1, data_lane2, data_lane3;
    logic [3:0]  lane_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] words_sent;

    always #5 clk_100mhz = ~clk_100mhz;

    lane_distributor #(.LANE_W(LANE_W), .IDLE_FILL(8'h00)) dut (
        .clk_100mhz   (clk_100mhz),
        .rst_n        (rst_n),
        .combined_data(combined_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .lane_mode    (lane_mode),
        .data_lane0   (data_lane0),
        .data_lane1   (data_lane1),
        .data_lane2   (data_lane2),
        .data_lane3   (data_lane3),
        .lane_valid   (lane_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .words_sent   (words_sent)
    );

    logic [31:0] lanes_obs;
    assign lanes_obs = {data_lane3, data_lane2, data_lane1, data_lane0};

    int checks = 0;
    int errors = 0;

    // Expected beats still to be transferred: {last_of_word, valid[3:0], lanes[31:0]}.
    logic [36:0] exp_q[$];
    logic [15:0] exp_words = 16'h0000;

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expand a word into its beats: 4/nbeats lanes per beat, bytes taken in order.
    task automatic push_word(input logic [31:0] w, input logic [1:0] m);
        int nb;
        int per;
        logic [31:0] lanes;
        logic [3:0]  v;
        nb  = (m == 2'd0) ? 1 : ((m == 2'd1) ? 2 : 4);
        per = 4 / nb;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 4; i++)
                lanes[8*i +: 8] = (i < per) ? w[8*(b*per+i) +: 8] : 8'h00;
            v = 4'((1 << per) - 1);
            exp_q.push_back({(b == nb-1), v, lanes});
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic [1:0] m, input logic ordy);
        logic xfer, acc, last, exp_ready;
        in_valid      = iv;
        combined_data = d;
        lane_mode     = m;
        out_ready     = ordy;
        #1;
        exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
        if (exp_q.size() != 0)
            chk("beat", {1'b0, lane_valid, lanes_obs}, {1'b0, exp_q[0][35:0]});
        else
            chk("idle_out", {1'b0, lane_valid, lanes_obs}, 37'h0);
        chk("in_ready", 37'(in_ready), 37'(exp_ready));
        chk("busy", 37'(busy), 37'(exp_q.size() != 0));
        chk("words_sent", 37'(words_sent), 37'(exp_words));
        xfer = (exp_q.size() != 0) && ordy;
        acc  = iv && exp_ready;
        @(posedge clk_100mhz);
        if (xfer) begin
            last = exp_q[0][36];
            void'(exp_q.pop_front());
            if (last) exp_words++;
        end
        if (acc) push_word(d, m);
        #1;
    endtask

    logic [7:0] seq3 [7];
    logic [7:0] seq5 [4];
    int         busy_cnt;
    logic [15:0] words_before;
    int         guard;

    initial begin
        seq3 = '{8'h21, 8'h43, 8'h43, 8'h43, 8'h43, 8'h65, 8'h87};
        seq5 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        rst_n = 1'b0; in_valid = 1'b0; combined_data = '0; lane_mode = '0; out_ready = 1'b0;
        #3;
        chk("rst_lanes", {1'b0, lane_valid, lanes_obs}, 37'h0);
        chk("rst_busy_words", 37'({busy, words_sent}), 37'h0);
        chk("rst_in_ready", 37'(in_ready), 37'h1);
        @(negedge clk_100mhz); rst_n = 1'b1;
        @(posedge clk_100mhz); #1;

        // 1: single 4-lane word
        cycle(1'b1, 32'hDDCCBBAA, 2'd0, 1'b1);
        chk("t1_beat", {1'b0, lane_valid, lanes_obs}, {1'b0, 4'hF, 32'hDDCCBBAA});
        cycle(1'b0, 32'h0, 2'd0, 1'b1);
        chk("t1_idle", {1'b0, lane_valid, lanes_obs}, 37'h0);
        chk("t1_words", 37'(words_sent), 37'd1);

        // 2: 2-lane word
        cycle(1'b1, 32'h44332211, 2'd1, 1'b1);
        chk("t2_beat0", {1'b0, lane_valid, lanes_obs}, {1'b0, 4'b0011, 32'h00002211});
        cycle(1'b0, 32'h0, 2'd1, 1'b1);
        chk("t2_beat1", {1'b0, lane_valid, lanes_obs}, {1'b0, 4'b0011, 32'h00004433});
        cycle(1'b0, 32'h0, 2'd1, 1'b1);

        // 3: 1-lane word with a 3-cycle stall on beat 1
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(i == 0, 32'h87654321, 2'd2, !(i >= 2 && i <= 4));
            if (i < 7) chk("t3_lane0", 37'(data_lane0), 37'(seq3[i]));
            busy_cnt += int'(busy);
        end
        chk("t3_busy_cycles", 37'(busy_cnt), 37'd7);

        // 4: five back-to-back 4-lane words
        words_before = words_sent;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h10203040 + 32'(i), 2'd0, 1'b1);
            chk("t4_valid", 37'(lane_valid), 37'hF);
        end
        cycle(1'b0, 32'h0, 2'd0, 1'b1);
        chk("t4_words", 37'(words_sent), 37'(words_before + 16'd5));

        // 5: lane_mode changes after accept must not affect the word in flight
        cycle(1'b1, 32'hA1B2C3D4, 2'd2, 1'b1);
        chk("t5_lane0", 37'(data_lane0), 37'(seq5[0]));
        for (int i = 1; i < 4; i++) begin
            cycle(1'b0, 32'h0, 2'd0, 1'b1);
            chk("t5_lane0", {1'b0, lane_valid, lanes_obs}, {1'b0, 4'b0001, 24'h0, seq5[i]});
        end
        cycle(1'b0, 32'h0, 2'd0, 1'b1);

        // 6: reset in the middle of a 1-lane word
        cycle(1'b1, 32'h0BADF00D, 2'd2, 1'b1);
        cycle(1'b0, 32'h0, 2'd2, 1'b1);
        #2; rst_n = 1'b0; #1;
        chk("t6_async_clear", {1'b0, lane_valid, lanes_obs}, 37'h0);
        chk("t6_busy_words", 37'({busy, words_sent}), 37'h0);
        exp_q.delete();
        exp_words = 16'h0000;
        @(negedge clk_100mhz); rst_n = 1'b1;
        @(posedge clk_100mhz); #1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 2'd2, 1'b1);
        chk("t6_words", 37'(words_sent), 37'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0);
        while (exp_q.size() != 0) cycle(1'b0, 32'h0, 2'd0, 1'b1);

        // words_sent wrap: fill to 16'hFFFF then send one more
        guard = 0;
        while ((int'(exp_words) + exp_q.size() < 65535) && guard < 70000) begin
            cycle(1'b1, $urandom, 2'd0, 1'b1);
            guard++;
        end
        while (exp_q.size() != 0 && guard < 70010) begin
            cycle(1'b0, 32'h0, 2'd0, 1'b1);
            guard++;
        end
        chk("wrap_pre", 37'(words_sent), 37'h0FFFF);
        cycle(1'b1, 32'h55AA55AA, 2'd0, 1'b1);
        cycle(1'b0, 32'h0, 2'd0, 1'b1);
        chk("wrap_post", 37'(words_sent), 37'h00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_distributor.md
Name: lane_distributor

Overview:
Splits a 32-bit word into four byte lanes. This is the transmit-side counterpart of the lane-combining logic.
- Accepts one word per valid/ready handshake.
- Emits the word as 1, 2 or 4 beats, depending on the number of active lanes (lane_mode).
- Sits between the datapath word stream and the physical lane drivers, in the clk_100mhz domain.

Parameters:
LANE_W, 8, width of each lane in bits; the word width is 4*LANE_W.
IDLE_FILL, 8'h00, value driven on inactive lanes and on all lanes when idle.

Ports:
clk_100mhz  input  1  block clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
combined_data  input  4*LANE_W  word to distribute; byte k = bits [k*LANE_W +: LANE_W].
in_valid  input  1  combined_data is valid.
in_ready  output  1  block can accept a word this cycle.
lane_mode  input  2  active lanes: 0 = 4 lanes, 1 = 2 lanes, 2 = 1 lane, 3 = 1 lane (reserved alias).
data_lane0  output  LANE_W  lane 0 data.
data_lane1  output  LANE_W  lane 1 data.
data_lane2  output  LANE_W  lane 2 data.
data_lane3  output  LANE_W  lane 3 data.
lane_valid  output  4  per-lane valid; bit i qualifies data_lanei.
out_ready  input  1  downstream accepts the current beat.
busy  output  1  a word is being sent.
words_sent  output  16  count of fully sent words.

Behaviour:
- Clock and reset: single clock clk_100mhz; reset is asynchronous, active-low (rst_n).
- Reset values:
  - state = IDLE.
  - data_lane0..3 = IDLE_FILL.
  - lane_valid = 4'b0000, busy = 0, words_sent = 0.
  - Holding register and beat counter = 0.
- Reset mid-operation: the partially sent word is discarded. No remaining beats are emitted after reset release.
- FSM states: IDLE, SEND.
- in_ready (combinational) = (state == IDLE) || (state == SEND && last_beat && out_ready).
- Accept: when in_valid && in_ready on a clock edge, the block registers:
  - combined_data;
  - lane_mode, decoded to NBEATS = 1 (mode 0), 2 (mode 1) or 4 (modes 2 and 3);
  - beat = 0.
  - The state becomes SEND.
- Latency: the first beat appears on the outputs in the cycle after acceptance (registered outputs, 1 cycle).
- Mode handling: lane_mode is sampled only at accept. Changes while in SEND have no effect on the current word.
- Beat mapping for beat index b:
  - mode 0: data_lanei = byte i for i = 0..3; lane_valid = 4'b1111.
  - mode 1: data_lane0 = byte 2b, data_lane1 = byte 2b+1; lanes 2 and 3 = IDLE_FILL; lane_valid = 4'b0011.
  - modes 2/3: data_lane0 = byte b; lanes 1..3 = IDLE_FILL; lane_valid = 4'b0001.
- Beat handshake: a beat transfers when any lane_valid bit is 1 and out_ready is 1. While out_ready = 0, all lane outputs and lane_valid hold stable.
- Advance: on a transfer of a non-last beat, beat increments and the next beat is presented the following cycle.
- Last beat (beat == NBEATS-1) transferred:
  - words_sent increments, wrapping 16'hFFFF -> 16'h0000.
  - If a new word is accepted in the same cycle, the state stays SEND with beat = 0 and the new word's first beat is presented next cycle. There are no bubbles back-to-back.
  - Otherwise the state returns to IDLE: lane_valid = 0, lanes = IDLE_FILL.
- busy = 1 exactly when state == SEND (registered).
- out_ready while IDLE is ignored.
- in_valid while SEND and not at the accept point: the word is not taken; upstream must hold it.
- Sustained throughput at out_ready = 1: one word per cycle in mode 0, per 2 cycles in mode 1, per 4 cycles in modes 2/3.

Test Plan:
1. Reset, then mode 0, word 32'hDDCCBBAA, out_ready = 1:
   - next cycle lanes 0..3 = AA, BB, CC, DD and lane_valid = 4'hF for 1 cycle;
   - then IDLE with words_sent = 1.
2. Mode 1, word 32'h44332211, out_ready = 1:
   - beat 0: lane0/1 = 11/22; beat 1: lane0/1 = 33/44;
   - lanes 2/3 = 00 throughout and lane_valid = 4'b0011 for 2 cycles;
   - in_ready = 1 only in the last-beat cycle.
3. Mode 2, word 32'h87654321, out_ready held low 3 cycles on beat 1:
   - lane0 reads 21, then 43 (held stable 3 cycles), then 65, then 87;
   - busy = 1 for 7 cycles.
4. Back-to-back mode 0, five words with in_valid and out_ready continuously 1:
   - five consecutive valid beats with no gap;
   - words_sent = 5.
5. lane_mode switched from 2 to 0 in the cycle after accepting 32'hA1B2C3D4:
   - the word still goes out as 4 single-lane beats D4, C3, B2, A1.
6. rst_n asserted on beat 1 of a mode 2 word:
   - outputs clear immediately (asynchronously);
   - after release, no stale beat appears, in_ready = 1, words_sent = 0.
   Additionally, preload words_sent = 16'hFFFF by sending 65535 words, then send one more -> words_sent = 0.
